// File: rtl/handshake_fifo.sv
// ---------------------------------------------------------------------------
// handshake_fifo
//
// Elastic buffer between a pulse-handshake upstream responder and a
// pulse-handshake downstream requester, decoupled by a depth-entry FIFO.
//
// Upstream side (this block is the requester):
//   req_l  out  registered request; held until ack_l arrives or FIFO fills
//   ack_l  in   one-cycle acknowledge; din valid while high
//   din    in   upstream data word
//
// Downstream side (this block is the responder):
//   req_r  in   request from downstream
//   ack_r  out  registered one-cycle acknowledge, never high two cycles running
//   dout   out  registered data word, valid while ack_r is high
//
// Status:
//   count      out  current occupancy, 0..depth
//   count_in   out  words accepted since reset (wraps at 2^32)
//   count_out  out  words delivered since reset (wraps at 2^32)
//   overflow   out  sticky; set when ack_l arrives while full
//
// Clock/reset: single rising-edge clock clk, asynchronous active-high rst.
// ---------------------------------------------------------------------------
module handshake_fifo #(
  parameter int data_width = 32,
  parameter int depth      = 4,
  parameter int addr_width = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_l,
  input  logic                  ack_l,
  input  logic [data_width-1:0] din,
  input  logic                  req_r,
  output logic                  ack_r,
  output logic [data_width-1:0] dout,
  output logic [addr_width:0]   count,
  output logic [31:0]           count_in,
  output logic [31:0]           count_out,
  output logic                  overflow
);

  localparam logic [addr_width:0]   L_DEPTH    = (addr_width+1)'(depth);
  localparam logic [addr_width:0]   L_CNT_ZERO = (addr_width+1)'(0);
  localparam logic [addr_width:0]   L_CNT_ONE  = (addr_width+1)'(1);
  localparam logic [addr_width-1:0] L_PTR_ZERO = (addr_width)'(0);
  localparam logic [addr_width-1:0] L_PTR_ONE  = (addr_width)'(1);

  // Storage and state
  logic [data_width-1:0] r_mem [depth];
  logic [addr_width-1:0] r_wptr;
  logic [addr_width-1:0] r_rptr;
  logic [addr_width:0]   r_count;
  logic [31:0]           r_count_in;
  logic [31:0]           r_count_out;
  logic                  r_req_l;
  logic                  r_ack_r;
  logic [data_width-1:0] r_dout;
  logic                  r_overflow;

  // Combinational decode
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_ovf_hit;
  logic [addr_width:0]   w_count_nxt;
  logic [addr_width:0]   w_post_occ;
  logic                  w_req_l_nxt;

  // Write/read qualification, next occupancy and next upstream request
  always_comb begin
    w_full      = 1'b0;
    w_empty     = 1'b0;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    w_ovf_hit   = 1'b0;
    w_count_nxt = r_count;
    w_post_occ  = r_count;
    w_req_l_nxt = 1'b0;

    w_full    = (r_count == L_DEPTH);
    w_empty   = (r_count == L_CNT_ZERO);
    w_wr      = ack_l & ~w_full;
    w_ovf_hit = ack_l & w_full;
    // Read uses the pre-edge occupancy, so a word written on this edge
    // cannot be returned on the same edge. ack_r gating keeps the
    // downstream acknowledge to single-cycle pulses.
    w_rd      = req_r & ~r_ack_r & ~w_empty;

    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + L_CNT_ONE;
      2'b01:   w_count_nxt = r_count - L_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase

    // Without an ack on this edge occupancy can only shrink, so the
    // request is raised only if a slot is free after any read.
    if (w_rd) begin
      w_post_occ = r_count - L_CNT_ONE;
    end else begin
      w_post_occ = r_count;
    end

    if (ack_l) begin
      w_req_l_nxt = 1'b0;
    end else if (w_post_occ < L_DEPTH) begin
      w_req_l_nxt = 1'b1;
    end else begin
      w_req_l_nxt = 1'b0;
    end
  end

  // Storage array write; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Pointers, occupancy, counters, handshake outputs and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= L_PTR_ZERO;
      r_rptr      <= L_PTR_ZERO;
      r_count     <= L_CNT_ZERO;
      r_count_in  <= 32'd0;
      r_count_out <= 32'd0;
      r_req_l     <= 1'b0;
      r_ack_r     <= 1'b0;
      r_dout      <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_req_l <= w_req_l_nxt;

      if (w_wr) begin
        r_wptr     <= r_wptr + L_PTR_ONE;
        r_count_in <= r_count_in + 32'd1;
      end

      if (w_ovf_hit) begin
        r_overflow <= 1'b1;
      end

      if (w_rd) begin
        r_ack_r     <= 1'b1;
        r_dout      <= r_mem[r_rptr];
        r_rptr      <= r_rptr + L_PTR_ONE;
        r_count_out <= r_count_out + 32'd1;
      end else begin
        r_ack_r     <= 1'b0;
      end
    end
  end

  assign req_l     = r_req_l;
  assign ack_r     = r_ack_r;
  assign dout      = r_dout;
  assign count     = r_count;
  assign count_in  = r_count_in;
  assign count_out = r_count_out;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_handshake_fifo.sv
// ---------------------------------------------------------------------------
// tb_handshake_fifo
//
// Directed bench for handshake_fifo (depth 4, 32-bit words). A bench-side
// producer model answers req_l with a one-cycle ack_l; the downstream
// request req_r is driven directly by each scenario task.
// ---------------------------------------------------------------------------
module tb_handshake_fifo;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic          req_l;
  logic          ack_l;
  logic [DW-1:0] din;
  logic          req_r;
  logic          ack_r;
  logic [DW-1:0] dout;
  logic [AW:0]   count;
  logic [31:0]   count_in;
  logic [31:0]   count_out;
  logic          overflow;

  int n_checks;
  int n_fail;

  // Producer model state
  logic        prod_en;
  logic [31:0] prod_val;
  logic [31:0] prod_limit;

  // Observation
  logic [31:0] rx_q[$];
  int          max_cnt;

  handshake_fifo #(
    .data_width (DW),
    .depth      (DP),
    .addr_width (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_l     (req_l),
    .ack_l     (ack_l),
    .din       (din),
    .req_r     (req_r),
    .ack_r     (ack_r),
    .dout      (dout),
    .count     (count),
    .count_in  (count_in),
    .count_out (count_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, record deliveries, then let the producer respond.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (ack_r === 1'b1) rx_q.push_back(dout);
    if (int'(count) > max_cnt) max_cnt = int'(count);
    if (prod_en) begin
      if (req_l === 1'b1 && prod_val < prod_limit) begin
        ack_l    = 1'b1;
        din      = prod_val;
        prod_val = prod_val + 32'd1;
      end else begin
        ack_l = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    ack_l   = 1'b0;
    req_r   = 1'b0;
    prod_en = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ack_l = 1'b0; din = '0; req_r = 1'b0;
    prod_en = 1'b0; prod_val = 32'd0; prod_limit = 32'd0;
    cycle();
    cycle();
    n_checks++;
    if ({req_l, ack_r, overflow} !== 3'b000 || dout !== 32'd0 || count !== 3'd0 ||
        count_in !== 32'd0 || count_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: req_l=%b ack_r=%b ovf=%b dout=%h count=%0d in=%0d out=%0d, want all 0",
               req_l, ack_r, overflow, dout, count, count_in, count_out);
    end
    rst = 1'b0;
    n_checks++;
    if (req_l !== 1'b0) begin
      n_fail++;
      $display("FAIL req_l_before_first_edge: got %b want 0", req_l);
    end
    cycle();
    n_checks++;
    if (req_l !== 1'b1 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL req_l_after_release: req_l=%b count=%0d want 1/0", req_l, count);
    end
  endtask

  task automatic test_fill();
    bit saw_ack;
    int i;
    saw_ack    = 1'b0;
    req_r      = 1'b0;
    prod_val   = 32'd0;
    prod_limit = 32'd4;
    prod_en    = 1'b1;
    i = 0;
    while (count !== 3'd4 && i < 40) begin
      cycle();
      if (ack_r !== 1'b0) saw_ack = 1'b1;
      i++;
    end
    n_checks++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_count: got %0d want 4", count);
    end
    n_checks++;
    if (req_l !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_req_l_on_full_edge: got %b want 0", req_l);
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (ack_r !== 1'b0) saw_ack = 1'b1;
      n_checks++;
      if (req_l !== 1'b0 || count !== 3'd4) begin
        n_fail++;
        $display("FAIL fill_hold: req_l=%b count=%0d want 0/4", req_l, count);
      end
    end
    n_checks++;
    if (saw_ack !== 1'b0 || overflow !== 1'b0 || count_in !== 32'd4) begin
      n_fail++;
      $display("FAIL fill_side: saw_ack=%b ovf=%b count_in=%0d want 0/0/4", saw_ack, overflow, count_in);
    end
  endtask

  task automatic test_drain();
    prod_en = 1'b0;
    ack_l   = 1'b0;
    req_r   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_checks++;
      if (ack_r !== ((i % 2) == 0)) begin
        n_fail++;
        $display("FAIL drain_ack_pattern[%0d]: got %b want %b", i, ack_r, ((i % 2) == 0));
      end else if (ack_r === 1'b1 && dout !== 32'(i / 2)) begin
        n_fail++;
        $display("FAIL drain_data[%0d]: got %h want %h", i, dout, 32'(i / 2));
      end
      if (i == 0) begin
        n_checks++;
        if (req_l !== 1'b1 || count !== 3'd3) begin
          n_fail++;
          $display("FAIL drain_first_read: req_l=%b count=%0d want 1/3", req_l, count);
        end
      end
    end
    n_checks++;
    if (count !== 3'd0 || count_out !== 32'd4) begin
      n_fail++;
      $display("FAIL drain_empty: count=%0d count_out=%0d want 0/4", count, count_out);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (ack_r !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_no_ack: got %b want 0", ack_r);
      end
    end
  endtask

  task automatic test_latency();
    req_r = 1'b1;
    ack_l = 1'b1;
    din   = 32'h0000_00A5;
    cycle();
    ack_l = 1'b0;
    n_checks++;
    if (ack_r !== 1'b0 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL latency_no_bypass: ack_r=%b count=%0d want 0/1", ack_r, count);
    end
    cycle();
    n_checks++;
    if (ack_r !== 1'b1 || dout !== 32'h0000_00A5 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL latency_deliver: ack_r=%b dout=%h count=%0d want 1/a5/0", ack_r, dout, count);
    end
    cycle();
  endtask

  task automatic test_overflow();
    int i;
    req_r      = 1'b0;
    prod_val   = 32'h10;
    prod_limit = 32'h14;
    prod_en    = 1'b1;
    i = 0;
    while (count !== 3'd4 && i < 40) begin
      cycle();
      i++;
    end
    prod_en = 1'b0;
    ack_l   = 1'b1;
    din     = 32'h0000_DEAD;
    cycle();
    ack_l   = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || count !== 3'd4 || count_in !== 32'd9) begin
      n_fail++;
      $display("FAIL overflow_set: ovf=%b count=%0d count_in=%0d want 1/4/9", overflow, count, count_in);
    end
    cycle();
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %b want 1", overflow);
    end
    rx_q.delete();
    req_r = 1'b1;
    for (int k = 0; k < 10; k++) cycle();
    n_checks++;
    if (rx_q.size() != 4) begin
      n_fail++;
      $display("FAIL overflow_drain_len: got %0d want 4", rx_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (rx_q[k] !== 32'h10 + 32'(k)) begin
          n_fail++;
          $display("FAIL overflow_drain_data[%0d]: got %h want %h", k, rx_q[k], 32'h10 + 32'(k));
        end
      end
    end
    n_checks++;
    if (count_out !== 32'd9 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_count_out: count_out=%0d ovf=%b want 9/1", count_out, overflow);
    end
  endtask

  task automatic test_stream();
    int i;
    apply_reset();
    rx_q.delete();
    max_cnt    = 0;
    prod_val   = 32'd0;
    prod_limit = 32'd1000;
    prod_en    = 1'b1;
    req_r      = 1'b1;
    i = 0;
    while (rx_q.size() < 1000 && i < 5000) begin
      cycle();
      n_checks++;
      if (count !== 3'(count_in - count_out)) begin
        n_fail++;
        $display("FAIL stream_count_invariant: count=%0d in=%0d out=%0d", count, count_in, count_out);
      end
      i++;
    end
    n_checks++;
    if (rx_q.size() != 1000) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d words want 1000", rx_q.size());
    end else begin
      for (int k = 0; k < 1000; k++) begin
        n_checks++;
        if (rx_q[k] !== 32'(k)) begin
          n_fail++;
          $display("FAIL stream_data[%0d]: got %0d want %0d", k, rx_q[k], k);
        end
      end
    end
    for (int k = 0; k < 4; k++) cycle();
    n_checks++;
    if (count_in !== 32'd1000 || count_out !== 32'd1000 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL stream_counters: in=%0d out=%0d count=%0d want 1000/1000/0", count_in, count_out, count);
    end
    n_checks++;
    if (max_cnt > 2) begin
      n_fail++;
      $display("FAIL stream_max_count: got %0d want <=2", max_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_next;
    int i;
    prod_limit = 32'd2000;
    prod_en    = 1'b1;
    req_r      = 1'b1;
    for (int k = 0; k < 15; k++) cycle();
    #3;
    rst   = 1'b1;
    ack_l = 1'b0;
    #1;
    n_checks++;
    if ({req_l, ack_r, overflow} !== 3'b000 || dout !== 32'd0 || count !== 3'd0 ||
        count_in !== 32'd0 || count_out !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: req_l=%b ack_r=%b ovf=%b dout=%h count=%0d in=%0d out=%0d, want all 0",
               req_l, ack_r, overflow, dout, count, count_in, count_out);
    end
    cycle();
    cycle();
    rst      = 1'b0;
    exp_next = prod_val;
    rx_q.delete();
    i = 0;
    while (rx_q.size() == 0 && i < 40) begin
      cycle();
      i++;
    end
    n_checks++;
    if (rx_q.size() == 0) begin
      n_fail++;
      $display("FAIL async_restart_timeout: no word within 40 cycles");
    end else if (rx_q[0] !== exp_next) begin
      n_fail++;
      $display("FAIL async_restart_first: got %0d want %0d", rx_q[0], exp_next);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    max_cnt  = 0;
    test_reset();
    test_fill();
    test_drain();
    test_latency();
    test_overflow();
    test_stream();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
